uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter (`tx_byte`/`transmit`/`is_transmitting` handshake) between NUM_SRC byte-stream sources, e.g. the debug packet streamer and a raw random-byte streamer. Grants are round-robin and locked for a whole packet, so packets from different sources never interleave. A stalled packet is aborted after a timeout so one source cannot hang the link. Sits between the sources and the UART TX module.

Parameters:
NUM_SRC, 2, number of requesting sources (2..8).
ACK_TIMEOUT, 4, cycles to wait for `is_transmitting` to rise after a `transmit` pulse before treating the byte as sent.
PKT_TIMEOUT, 1024, idle cycles allowed inside a locked packet (`src_valid` low) before abort.

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous, active-low.
src_valid  in  NUM_SRC  source i has a byte on `src_data`.
src_data  in  8*NUM_SRC  byte of source i in bits [8i+7:8i].
src_last  in  NUM_SRC  byte of source i is the last byte of its packet.
src_ack  out  NUM_SRC  one-cycle pulse: byte of source i consumed.
is_transmitting  in  1  UART busy.
tx_byte  out  8  byte to UART.
transmit  out  1  one-cycle strobe: `tx_byte` valid.
grant  out  NUM_SRC  one-hot owner of the link; 0 when idle.
pkt_abort  out  1  one-cycle pulse on packet timeout.

Behaviour:
- Reset (`rst` low, asynchronous): `tx_byte`=0, `transmit`=0, `src_ack`=0, `grant`=0, `pkt_abort`=0, state IDLE, round-robin pointer=0, counters=0.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If any `src_valid` is high, pick the first valid source at or after the pointer (wrapping modulo NUM_SRC).
  - Set `grant` to that source and go to ISSUE next cycle.
- ISSUE:
  - Only acts when `is_transmitting`=0 and the granted `src_valid`=1.
  - Registers `tx_byte`=`src_data[granted]`, pulses `transmit` and `src_ack[granted]` for one cycle.
  - Latches `src_last` internally, goes to WAIT_ACK.
  - Issue latency from `src_valid` to `transmit` is 1 cycle in ISSUE and 2 cycles from IDLE.
- WAIT_ACK:
  - On `is_transmitting`=1, go to WAIT_DONE.
  - If `is_transmitting` stays low for ACK_TIMEOUT cycles, treat the byte as done.
- WAIT_DONE (or ACK timeout):
  - On `is_transmitting`=0: if the latched last=1, set pointer=granted+1 (wrapping), `grant`=0, go to IDLE.
  - Otherwise return to ISSUE.
- Never two `transmit` pulses without an intervening return to ISSUE; `transmit` is never high while `is_transmitting` is high at the issue cycle.
- Packet timeout:
  - In ISSUE with granted `src_valid`=0, an idle counter increments and is cleared on each issue.
  - At PKT_TIMEOUT: pulse `pkt_abort`, `grant`=0, pointer=granted+1, go to IDLE. No `src_ack`.
- Simultaneous requests: round-robin order only; a non-granted `src_valid` is ignored until the owner's last byte has been sent.
- `src_valid` deasserted by a non-owner: no effect.
- Owner's `src_data` may change freely between acks; it is sampled only in the issue cycle.
- Single-byte packet (`src_last`=1 on first byte): grant released after that byte.
- Reset mid-operation: immediate return to reset values. The UART may finish its current byte; the arbiter waits in IDLE/ISSUE for `is_transmitting`=0 before issuing.

Optional Feature:
- Macro: UART_TX_ARB_TAG_EN.
- Defined: on grant, before the first source byte, ISSUE sends a tag byte {4'hA, 1'b0, source index[2:0]} with no `src_ack`, then the packet proceeds normally. The tag obeys the same ACK/DONE handshake. Timeout counting starts after the tag.
- Undefined: no tag byte; a packet's bytes are sent unmodified.

Decomposition:
- Shared package (uart_tx_arb_pkg): state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT_ACK=2'd2, WAIT_DONE=2'd3), TAG_PREFIX=4'hA, and a function for round-robin next-index.
- One natural sub-module: rr_picker, combinational plus pointer register, inputs `src_valid`/pointer, output one-hot pick.

Test Plan:
- Source0 sends 3-byte packet 0x55,0x12,0xAA (last on 0xAA); UART model busy 10 cycles per byte -> exactly 3 `transmit` pulses with those bytes, 3 `src_ack[0]`, `grant` returns to 0.
- Both sources valid from reset, each sending a 2-byte packet -> order src0 packet, then src1 packet, no interleaving; the next contention goes to src1 first after a src0 packet.
- Source1 sends first byte then drops `src_valid` for PKT_TIMEOUT=16 (test override) cycles -> `pkt_abort` pulses once, `grant`=0, and a waiting src0 is granted next.
- UART model never raises `is_transmitting` -> after a `transmit`, the next byte is issued ACK_TIMEOUT+1 cycles later.
- `rst` asserted low mid-packet while `is_transmitting`=1 -> outputs zero immediately; after release, no `transmit` until `is_transmitting`=0.
- With UART_TX_ARB_TAG_EN, src1 sends 1-byte packet 0x7E -> bytes 0xA1, 0x7E; one `src_ack`.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared state encoding, tag prefix and round-robin helper for the UART TX arbiter.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    typedef logic [2:0] src_idx_t;

    localparam logic [3:0] TAG_PREFIX = 4'hA;

    function automatic src_idx_t rr_next(input src_idx_t idx, input int num_src);
        if (int'(idx) >= num_src - 1) return '0;
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: holds the priority pointer and selects the first valid
// source at or after it, wrapping modulo NUM_SRC.
module rr_picker
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_valid,
    input  logic               advance,
    input  src_idx_t           owner_idx,
    output logic [NUM_SRC-1:0] pick,
    output src_idx_t           pick_idx
);

    src_idx_t ptr;
    int       pos;
    logic     found;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= rr_next(owner_idx, NUM_SRC);
        end
    end

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        pos      = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_SRC) pos = pos - NUM_SRC;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!found && pos == i && src_valid[i]) begin
                    found    = 1'b1;
                    pick[i]  = 1'b1;
                    pick_idx = src_idx_t'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmitter between sources.
// Define UART_TX_ARB_TAG_EN to prefix every granted packet with a source tag byte.
//
// state     | meaning
// IDLE      | no owner; grant the next valid source in round-robin order
// ISSUE     | owner holds the link; send its byte (or the tag) once UART is free
// WAIT_ACK  | byte strobed; waiting for is_transmitting to rise or ACK timeout
// WAIT_DONE | UART busy with the byte; waiting for it to finish
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int ACK_TIMEOUT = 4,
    parameter int PKT_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ack,
    input  logic                 is_transmitting,
    output logic [7:0]           tx_byte,
    output logic                 transmit,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 pkt_abort
);

    localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int IDLE_W = $clog2(PKT_TIMEOUT + 1);
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(PKT_TIMEOUT - 1);

    arb_state_t          state;
    src_idx_t            gidx;
    logic                last_q;
    logic [ACK_W-1:0]    ack_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [NUM_SRC-1:0]  pick;
    src_idx_t            pick_idx;
    logic                owner_valid;
    logic                owner_last;
    logic [7:0]          owner_data;
    logic                byte_done;
    logic                abort_hit;
    logic                advance;
    logic                tag_busy;

`ifdef UART_TX_ARB_TAG_EN
    logic tag_pending;
    assign tag_busy = tag_pending;
`else
    assign tag_busy = 1'b0;
`endif

    assign owner_valid = |(src_valid & grant);
    assign owner_last  = |(src_last & grant);

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) owner_data = owner_data | src_data[8*i +: 8];
        end
    end

    // An ACK timeout is treated exactly like a completed byte.
    assign byte_done = !is_transmitting &&
                       ((state == WAIT_DONE) || (state == WAIT_ACK && ack_cnt == ACK_LAST));
    assign abort_hit = (state == ISSUE) && !tag_busy && !owner_valid && (idle_cnt == IDLE_LAST);
    assign advance   = (byte_done && last_q) || abort_hit;

    rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .advance   (advance),
        .owner_idx (gidx),
        .pick      (pick),
        .pick_idx  (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gidx      <= '0;
            last_q    <= 1'b0;
            ack_cnt   <= '0;
            idle_cnt  <= '0;
            tx_byte   <= '0;
            transmit  <= 1'b0;
            src_ack   <= '0;
            grant     <= '0;
            pkt_abort <= 1'b0;
`ifdef UART_TX_ARB_TAG_EN
            tag_pending <= 1'b0;
`endif
        end else begin
            transmit  <= 1'b0;
            src_ack   <= '0;
            pkt_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (|src_valid) begin
                        grant    <= pick;
                        gidx     <= pick_idx;
                        idle_cnt <= '0;
                        state    <= ISSUE;
`ifdef UART_TX_ARB_TAG_EN
                        tag_pending <= 1'b1;
`endif
                    end
                end
                ISSUE: begin
`ifdef UART_TX_ARB_TAG_EN
                    if (tag_pending) begin
                        if (!is_transmitting) begin
                            tx_byte     <= {TAG_PREFIX, 1'b0, gidx};
                            transmit    <= 1'b1;
                            last_q      <= 1'b0;
                            tag_pending <= 1'b0;
                            ack_cnt     <= '0;
                            state       <= WAIT_ACK;
                        end
                    end else
`endif
                    if (abort_hit) begin
                        pkt_abort <= 1'b1;
                        grant     <= '0;
                        idle_cnt  <= '0;
                        state     <= IDLE;
                    end else if (!owner_valid) begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end else if (!is_transmitting) begin
                        tx_byte  <= owner_data;
                        transmit <= 1'b1;
                        src_ack  <= grant;
                        last_q   <= owner_last;
                        idle_cnt <= '0;
                        ack_cnt  <= '0;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK, WAIT_DONE: begin
                    if (byte_done) begin
                        if (last_q) begin
                            grant <= '0;
                            state <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end else if (state == WAIT_ACK) begin
                        if (is_transmitting) state <= WAIT_DONE;
                        else                 ack_cnt <= ack_cnt + ACK_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single-source packet table, round-robin
// contention, packet abort, ACK timeout and mid-packet reset sequences.
module tb_uart_tx_arbiter;

    localparam int NUM_SRC     = 2;
    localparam int ACK_TIMEOUT = 4;
    localparam int PKT_TIMEOUT = 16;
    localparam int BUSY        = 10;
`ifdef UART_TX_ARB_TAG_EN
    localparam int TAGN = 1;
`else
    localparam int TAGN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  src_valid = '0;
    logic [15:0] src_data = '0;
    logic [1:0]  src_last = '0;
    logic [1:0]  src_ack;
    logic        is_transmitting = 1'b0;
    logic [7:0]  tx_byte;
    logic        transmit;
    logic [1:0]  grant;
    logic        pkt_abort;

    uart_tx_arbiter #(
        .NUM_SRC(NUM_SRC), .ACK_TIMEOUT(ACK_TIMEOUT), .PKT_TIMEOUT(PKT_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
        .src_last(src_last), .src_ack(src_ack), .is_transmitting(is_transmitting),
        .tx_byte(tx_byte), .transmit(transmit), .grant(grant), .pkt_abort(pkt_abort)
    );

    always #5 clk = ~clk;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] tx_log[$];
    logic [1:0] tx_grant[$];
    int         tx_cyc[$];
    logic [7:0] exp_q[$];
    logic       uart_dead = 1'b0;
    logic       force_busy = 1'b0;
    int         busy_cnt = 0;
    int         cyc = 0;
    int         ack0 = 0, ack1 = 0, abort_cnt = 0, proto_viol = 0;
    logic [1:0] abort_grant = '0;
    int         vec_n = 0, miscompares = 0;

    typedef struct {
        int         src;
        int         len;
        logic [7:0] b0, b1, b2;
        int         exp_tx;
        int         exp_ack;
    } vec_t;
    vec_t vt[5];

    // Sources, UART model and monitor all advance on the falling edge.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (transmit) begin
            if (is_transmitting) proto_viol++;
            tx_log.push_back(tx_byte);
            tx_grant.push_back(grant);
            tx_cyc.push_back(cyc);
        end
        if (pkt_abort) begin
            abort_cnt++;
            abort_grant = grant;
        end
        if (src_ack[0]) begin ack0++; if (q0.size() > 0) q0.delete(0); end
        if (src_ack[1]) begin ack1++; if (q1.size() > 0) q1.delete(0); end
        if (transmit && !uart_dead) busy_cnt = BUSY;
        else if (busy_cnt > 0)      busy_cnt--;
        is_transmitting = (busy_cnt > 0) || force_busy;
        src_valid[0]   = q0.size() > 0;
        src_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        src_last[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
        src_valid[1]   = q1.size() > 0;
        src_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        src_last[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
    end

    task automatic check(input string name, input int got, input int exp);
        vec_n++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_pkt(input int src, input int len,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = (i == 0) ? b0 : (i == 1) ? b1 : b2;
            if (src == 0) q0.push_back({i == len - 1, b});
            else          q1.push_back({i == len - 1, b});
        end
    endtask

    task automatic add_exp(input int src, input int len,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        if (TAGN == 1) exp_q.push_back(8'hA0 | 8'(src));
        if (len > 0) exp_q.push_back(b0);
        if (len > 1) exp_q.push_back(b1);
        if (len > 2) exp_q.push_back(b2);
    endtask

    task automatic clear_logs();
        tx_log.delete(); tx_grant.delete(); tx_cyc.delete(); exp_q.delete();
        ack0 = 0; ack1 = 0; abort_cnt = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && grant == 2'b00 &&
                 !is_transmitting && busy_cnt == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            vec_n++;
            miscompares++;
            $display("FAIL %s: timeout waiting for idle, grant=%b", name, grant);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_log(input string name, input int exp_count);
        check({name, " tx count"}, tx_log.size(), exp_count);
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
            check($sformatf("%s byte%0d", name, i), tx_log[i], exp_q[i]);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vt[0] = '{0, 3, 8'h55, 8'h12, 8'hAA, 3 + TAGN, 3};
        vt[1] = '{1, 1, 8'h7E, 8'h00, 8'h00, 1 + TAGN, 1};
        vt[2] = '{1, 2, 8'h01, 8'hFF, 8'h00, 2 + TAGN, 2};
        vt[3] = '{0, 1, 8'h00, 8'h00, 8'h00, 1 + TAGN, 1};
        vt[4] = '{1, 3, 8'h80, 8'h7F, 8'h33, 3 + TAGN, 3};

        repeat (3) @(negedge clk);
        check("reset tx_byte", tx_byte, 0);
        check("reset transmit", transmit, 0);
        check("reset src_ack", src_ack, 0);
        check("reset grant", grant, 0);
        check("reset pkt_abort", pkt_abort, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            clear_logs();
            @(posedge clk); #1;
            push_pkt(vt[v].src, vt[v].len, vt[v].b0, vt[v].b1, vt[v].b2);
            add_exp(vt[v].src, vt[v].len, vt[v].b0, vt[v].b1, vt[v].b2);
            @(negedge clk);
            @(negedge clk);
            check($sformatf("vec%0d grant", v), grant, 1 << vt[v].src);
            @(negedge clk);
            check($sformatf("vec%0d first transmit latency", v), transmit, 1);
            wait_idle($sformatf("vec%0d", v));
            compare_log($sformatf("vec%0d", v), vt[v].exp_tx);
            check($sformatf("vec%0d acks", v), (vt[v].src == 0) ? ack0 : ack1, vt[v].exp_ack);
            check($sformatf("vec%0d grant released", v), grant, 0);
        end

        // Contention with pointer at 0: src0 packet first, then src1.
        clear_logs();
        @(posedge clk); #1;
        push_pkt(0, 2, 8'h10, 8'h11, 8'h00);
        push_pkt(1, 2, 8'h20, 8'h21, 8'h00);
        add_exp(0, 2, 8'h10, 8'h11, 8'h00);
        add_exp(1, 2, 8'h20, 8'h21, 8'h00);
        @(negedge clk); @(negedge clk);
        check("rr1 first grant", grant, 2'b01);
        wait_idle("rr1");
        compare_log("rr1", 4 + 2 * TAGN);
        if (tx_grant.size() == 4 + 2 * TAGN) check("rr1 last owner", tx_grant[3 + 2 * TAGN], 2'b10);

        // After a lone src0 packet, the next contention must go to src1 first.
        clear_logs();
        @(posedge clk); #1;
        push_pkt(0, 1, 8'h30, 8'h00, 8'h00);
        wait_idle("rr2 solo");
        clear_logs();
        @(posedge clk); #1;
        push_pkt(0, 1, 8'h40, 8'h00, 8'h00);
        push_pkt(1, 1, 8'h50, 8'h00, 8'h00);
        add_exp(1, 1, 8'h50, 8'h00, 8'h00);
        add_exp(0, 1, 8'h40, 8'h00, 8'h00);
        wait_idle("rr2");
        compare_log("rr2", 2 + 2 * TAGN);

        // src1 stalls after its first byte; src0 waits and gets the link after the abort.
        clear_logs();
        @(posedge clk); #1;
        q1.push_back({1'b0, 8'h91});
        push_pkt(0, 1, 8'h33, 8'h00, 8'h00);
        add_exp(1, 1, 8'h91, 8'h00, 8'h00);
        add_exp(0, 1, 8'h33, 8'h00, 8'h00);
        wait_idle("abort");
        compare_log("abort", 2 + 2 * TAGN);
        check("abort pulses", abort_cnt, 1);
        check("abort grant", abort_grant, 0);
        check("abort src1 acks", ack1, 1);
        check("abort src0 acks", ack0, 1);
        if (tx_grant.size() == 2 + 2 * TAGN) check("abort next owner", tx_grant[1 + 2 * TAGN], 2'b01);

        // UART never acknowledges: next byte goes out ACK_TIMEOUT+1 cycles later.
        clear_logs();
        uart_dead = 1'b1;
        @(posedge clk); #1;
        push_pkt(0, 2, 8'h61, 8'h62, 8'h00);
        add_exp(0, 2, 8'h61, 8'h62, 8'h00);
        wait_idle("ack timeout");
        compare_log("ack timeout", 2 + TAGN);
        if (tx_cyc.size() == 2 + TAGN)
            check("ack timeout gap", tx_cyc[1 + TAGN] - tx_cyc[TAGN], ACK_TIMEOUT + 1);
        uart_dead = 1'b0;

        // Reset in the middle of a packet while the UART is busy.
        clear_logs();
        @(posedge clk); #1;
        push_pkt(0, 2, 8'hC1, 8'hC2, 8'h00);
        n = 0;
        while (tx_log.size() < 1 + TAGN && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            vec_n++;
            miscompares++;
            $display("FAIL reset setup: timeout waiting for first byte, got %0d bytes", tx_log.size());
        end
        repeat (3) @(negedge clk);
        force_busy = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("mid reset transmit", transmit, 0);
        check("mid reset tx_byte", tx_byte, 0);
        check("mid reset grant", grant, 0);
        check("mid reset src_ack", src_ack, 0);
        check("mid reset pkt_abort", pkt_abort, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_logs();
        repeat (8) @(negedge clk);
        check("no transmit while busy after reset", tx_log.size(), 0);
        force_busy = 1'b0;
        add_exp(0, 1, 8'hC2, 8'h00, 8'h00);
        wait_idle("post reset");
        compare_log("post reset", 1 + TAGN);
        check("post reset acks", ack0, 1);

        check("transmit while busy", proto_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miscompares);
        $finish;
    end

endmodule
